// File: rtl/free_list_pkg.sv
// Shared rename-stage types: physical register sizing and slot-rank helpers.
// Reused by the free list, rename table and retirement RAT.
package free_list_pkg;

   localparam int SS        = 2;
   localparam int NUM_PREGS = 64;
   localparam int NUM_AREGS = 32;
   localparam int PREG_W    = $clog2(NUM_PREGS);
   localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;

   typedef logic [PREG_W-1:0] preg_t;

   // Number of set bits strictly below position i (slot rank).
   function automatic int unsigned rank_below(
      input logic [31:0] v,
      input int unsigned i
   );
      int unsigned r;
      r = 0;
      for (int unsigned k = 0; k < 32; k++) begin
         if (k < i && v[k]) r++;
      end
      return r;
   endfunction

   function automatic int unsigned popcount(
      input logic [31:0] v
   );
      return rank_below(v, 32);
   endfunction

endpackage

// File: rtl/free_list.sv
// Circular FIFO of unmapped physical registers feeding rename.
// Head/tail carry a wrap bit so full and empty are distinguishable.
module free_list
   import free_list_pkg::*;
#(
   parameter  int SS        = 2,
   parameter  int NUM_PREGS = 64,
   parameter  int NUM_AREGS = 32,
   localparam int PW        = $clog2(NUM_PREGS),
   localparam int DEPTH     = NUM_PREGS - NUM_AREGS,
   localparam int IW        = $clog2(DEPTH),
   localparam int CW        = IW + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [SS-1:0]          deq_req,
   output logic                   deq_ready,
   output logic [SS-1:0][PW-1:0]  deq_preg,
   input  logic [SS-1:0]          enq_en,
   input  logic [SS-1:0][PW-1:0]  enq_preg,
   input  logic                   flush,
   output logic [CW-1:0]          count
);

   localparam logic [CW-1:0] WRAP = CW'(DEPTH);

   logic [PW-1:0]         mem [DEPTH];
   logic [CW-1:0]         head;
   logic [CW-1:0]         tail;
   logic [CW-1:0]         n_deq;
   logic [CW-1:0]         n_enq;
   logic [SS-1:0]         enq_vld;
   logic [SS-1:0]         enq_wr;
   logic [SS-1:0][CW-1:0] rd_ptr;
   logic [SS-1:0][CW-1:0] wr_ptr;

   assign count = tail - head;

   always_comb begin
      n_deq     = CW'(popcount(32'(deq_req)));
      deq_ready = !flush && (count >= n_deq);
      for (int i = 0; i < SS; i++) begin
         rd_ptr[i]   = head + CW'(rank_below(32'(deq_req), i));
         deq_preg[i] = deq_req[i] ? mem[rd_ptr[i][IW-1:0]] : '0;
      end
   end

   // x0 is never renamed, so a returned preg of 0 is just dropped.
   always_comb begin
      n_enq = '0;
      for (int i = 0; i < SS; i++) begin
         enq_vld[i] = enq_en[i] && (enq_preg[i] != '0);
      end
      for (int i = 0; i < SS; i++) begin
         wr_ptr[i] = tail + CW'(rank_below(32'(enq_vld), i));
         enq_wr[i] = enq_vld[i]
                  && (int'(count)
                      + int'(rank_below(32'(enq_vld), i))
                      < DEPTH);
         if (enq_wr[i]) n_enq = n_enq + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= WRAP;
         for (int k = 0; k < DEPTH; k++) begin
            mem[k] <= PW'(NUM_AREGS + k);
         end
      end else if (flush) begin
         head <= tail ^ WRAP;
      end else begin
         if (deq_ready) head <= head + n_deq;
         tail <= tail + n_enq;
         for (int i = 0; i < SS; i++) begin
            if (enq_wr[i]) mem[wr_ptr[i][IW-1:0]] <= enq_preg[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         assert (int'(count) + int'(popcount(32'(enq_vld))) <= DEPTH);
      end
   end

endmodule

// File: tb/tb_free_list.sv
// Directed scoreboard bench for free_list.
// Driver queues expected outputs; a negedge monitor pops and compares.
module tb_free_list;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      deq_req;
   logic            deq_ready;
   logic [1:0][5:0] deq_preg;
   logic [1:0]      enq_en;
   logic [1:0][5:0] enq_preg;
   logic            flush;
   logic [5:0]      count;

   typedef struct {
      int rdy;
      int p0;
      int p1;
      int cnt;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   free_list dut (
      .clk       (clk),
      .rst       (rst),
      .deq_req   (deq_req),
      .deq_ready (deq_ready),
      .deq_preg  (deq_preg),
      .enq_en    (enq_en),
      .enq_preg  (enq_preg),
      .flush     (flush),
      .count     (count)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if ($isunknown({deq_ready, deq_preg, count})) begin
               n_assert++;
               n_fail++;
               $display("FAIL xcheck: unknown outputs (t=%0t)", $time);
            end
            if (e.rdy >= 0) chk("deq_ready", int'(deq_ready), e.rdy);
            if (e.p0 >= 0) chk("deq_preg0", int'(deq_preg[0]), e.p0);
            if (e.p1 >= 0) chk("deq_preg1", int'(deq_preg[1]), e.p1);
            if (e.cnt >= 0) chk("count", int'(count), e.cnt);
         end
      end
   end

   task automatic drive(
      input logic       r,
      input logic       fl,
      input logic [1:0] req,
      input logic [1:0] en,
      input logic [5:0] e0,
      input logic [5:0] e1
   );
      @(posedge clk);
      #1;
      rst         = r;
      flush       = fl;
      deq_req     = req;
      enq_en      = en;
      enq_preg[0] = e0;
      enq_preg[1] = e1;
   endtask

   task automatic expect_o(input int rdy, p0, p1, cnt);
      exp_t e;
      e.rdy = rdy;
      e.p0  = p0;
      e.p1  = p1;
      e.cnt = cnt;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
      drive(1'b1, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
   endtask

   task automatic drain_all();
      for (int k = 0; k < 16; k++) begin
         drive(1'b0, 1'b0, 2'b11, 2'b00, 6'd0, 6'd0);
         expect_o(1, 32 + 2 * k, 33 + 2 * k, 32 - 2 * k);
      end
   endtask

   initial begin
      rst      = 1'b1;
      flush    = 1'b0;
      deq_req  = '0;
      enq_en   = '0;
      enq_preg = '0;

      // reset then idle: full, ready, nothing granted
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
         expect_o(1, 0, 0, 32);
      end

      // drain in pairs, then requests at empty stall
      drain_all();
      drive(1'b0, 1'b0, 2'b11, 2'b00, 6'd0, 6'd0);
      expect_o(0, 32, 33, 0);
      drive(1'b0, 1'b0, 2'b01, 2'b00, 6'd0, 6'd0);
      expect_o(0, 32, 0, 0);
      drive(1'b0, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
      expect_o(1, 0, 0, 0);

      // only slot 1 requesting gets the head entry
      do_reset();
      drive(1'b0, 1'b0, 2'b10, 2'b00, 6'd0, 6'd0);
      expect_o(1, 0, 32, 32);
      drive(1'b0, 1'b0, 2'b01, 2'b00, 6'd0, 6'd0);
      expect_o(1, 33, 0, 31);
      drive(1'b0, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
      expect_o(1, 0, 0, 30);

      // empty list refilled across the wrap, preg 0 dropped
      do_reset();
      drain_all();
      drive(1'b0, 1'b0, 2'b00, 2'b11, 6'd5, 6'd0);
      expect_o(1, 0, 0, 0);
      drive(1'b0, 1'b0, 2'b00, 2'b11, 6'd7, 6'd9);
      expect_o(1, 0, 0, 1);
      drive(1'b0, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
      expect_o(1, 0, 0, 3);
      drive(1'b0, 1'b0, 2'b11, 2'b00, 6'd0, 6'd0);
      expect_o(1, 5, 7, 3);
      drive(1'b0, 1'b0, 2'b01, 2'b00, 6'd0, 6'd0);
      expect_o(1, 9, 0, 1);
      drive(1'b0, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
      expect_o(1, 0, 0, 0);

      // count 1, two requests stall while two enqueues land
      drive(1'b0, 1'b0, 2'b00, 2'b01, 6'd20, 6'd0);
      expect_o(1, 0, 0, 0);
      drive(1'b0, 1'b0, 2'b11, 2'b11, 6'd40, 6'd41);
      expect_o(0, 20, 36, 1);
      drive(1'b0, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
      expect_o(1, 0, 0, 3);
      drive(1'b0, 1'b0, 2'b11, 2'b00, 6'd0, 6'd0);
      expect_o(1, 20, 40, 3);
      drive(1'b0, 1'b0, 2'b01, 2'b00, 6'd0, 6'd0);
      expect_o(1, 41, 0, 1);
      drive(1'b0, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
      expect_o(1, 0, 0, 0);

      // flush after 10 pops, with an enqueue that must be ignored
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b0, 2'b11, 2'b00, 6'd0, 6'd0);
         expect_o(1, 32 + 2 * k, 33 + 2 * k, 32 - 2 * k);
      end
      drive(1'b0, 1'b1, 2'b00, 2'b01, 6'd12, 6'd0);
      expect_o(0, 0, 0, 22);
      drive(1'b0, 1'b0, 2'b01, 2'b00, 6'd0, 6'd0);
      expect_o(1, 32, 0, 32);
      drive(1'b0, 1'b1, 2'b11, 2'b00, 6'd0, 6'd0);
      expect_o(0, 33, 34, 31);
      drive(1'b0, 1'b0, 2'b11, 2'b00, 6'd0, 6'd0);
      expect_o(1, 32, 33, 32);
      drive(1'b0, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
      expect_o(1, 0, 0, 30);

      for (int k = 0; k < 20; k++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      #1;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0",
                  sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
